// File: rtl/acq_pkg.sv
// Shared types for the acquisition trigger controller: FSM states, mode codes, sample width.
package acq_pkg;

  localparam int unsigned SAMPLE_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_FILL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POST     = 3'd3,
    ST_READY    = 3'd4
  } acq_state_t;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_RSVD   = 2'b11
  } acq_mode_t;

endpackage

// File: rtl/trig_detect.sv
// Level-crossing detector: remembers the previous sample and flags a crossing on the current one.
module trig_detect
  import acq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                slope,
  output logic                hit_c
);

  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;

  // Dropping enable invalidates history so the first sample after re-enable cannot fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (!enable) begin
      prev_valid <= 1'b0;
    end else if (sample_valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    hit_c = 1'b0;
    if (enable && sample_valid && prev_valid) begin
      if (slope) hit_c = (prev > level) && (sample <= level);
      else       hit_c = (prev < level) && (sample >= level);
    end
  end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Oscilloscope-style capture controller: pre-trigger fill, level/auto trigger, post-trigger fill,
// then holds the frame for the display.
module acq_trigger_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned PRE_TRIG     = 256,
  parameter int unsigned AUTO_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trigger_level,
  input  logic                trig_slope,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic                disp_done,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                capture_ready,
  output logic [ADDR_W-1:0]   disp_start,
  output logic                auto_trig,
  output logic [2:0]          state_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned POST_N = DEPTH - PRE_TRIG - 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned TO_W   = $clog2(AUTO_TIMEOUT + 1);

  acq_state_t        state;
  acq_mode_t         mode_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;
  logic              capturing_c;
  logic              take_c;
  logic              hit_c;
  logic              timeout_c;

  assign capturing_c = state inside {ST_PRE_FILL, ST_ARMED, ST_POST};
  assign take_c      = capturing_c && sample_valid;
  assign timeout_c   = (state == ST_ARMED) && (mode_q == MODE_AUTO) &&
                       (tcnt == TO_W'(AUTO_TIMEOUT - 1));
  assign state_o     = state;

  trig_detect u_trig_detect (
    .clk          (clk),
    .rst          (rst),
    .enable       (state == ST_ARMED),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (trigger_level),
    .slope        (trig_slope),
    .hit_c        (hit_c)
  );

  // Buffer write port; ptr runs continuously across frames and wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ptr     <= '0;
    end else begin
      wr_en <= take_c;
      if (take_c) begin
        wr_addr <= ptr;
        wr_data <= sample;
        ptr     <= ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_NORMAL;
      cnt           <= '0;
      tcnt          <= '0;
      trig_addr     <= '0;
      capture_ready <= 1'b0;
      disp_start    <= '0;
      auto_trig     <= 1'b0;
    end else begin
      tcnt <= (state == ST_ARMED) ? tcnt + TO_W'(1) : '0;
      case (state)
        ST_IDLE: begin
          if (acq_mode_t'(mode) != MODE_SINGLE || arm) begin
            mode_q <= acq_mode_t'(mode);
            cnt    <= '0;
            state  <= ST_PRE_FILL;
          end
        end
        ST_PRE_FILL: begin
          if (sample_valid) begin
            if (cnt == CNT_W'(PRE_TRIG - 1)) begin
              cnt   <= '0;
              state <= ST_ARMED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_ARMED: begin
          // A real crossing takes priority over a simultaneous timeout.
          if (hit_c) begin
            trig_addr <= ptr;
            auto_trig <= 1'b0;
            cnt       <= '0;
            state     <= ST_POST;
          end else if (timeout_c) begin
            trig_addr <= sample_valid ? ptr : ptr - ADDR_W'(1);
            auto_trig <= 1'b1;
            cnt       <= '0;
            state     <= ST_POST;
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            if (cnt == CNT_W'(POST_N - 1)) begin
              cnt           <= '0;
              capture_ready <= 1'b1;
              disp_start    <= trig_addr - ADDR_W'(PRE_TRIG);
              state         <= ST_READY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_READY: begin
          if (disp_done) begin
            capture_ready <= 1'b0;
            mode_q        <= acq_mode_t'(mode);
            cnt           <= '0;
            state         <= (mode_q == MODE_SINGLE) ? ST_IDLE : ST_PRE_FILL;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
